// File: rtl/c1_4_load_sequencer.sv
// c1_4_load_sequencer: forces a preset into the T-flip-flop counter, then enables it for N steps.
// Ports: clk/reset_n (async active-low); cmd_valid/cmd_ready handshake with cmd_preset,
// cmd_reverse, cmd_steps; abort cancels; enable/reverse/load[0:5] drive the counter;
// busy is high outside IDLE; done pulses one cycle at completion.
module c1_4_load_sequencer #(
  parameter int LOAD_CYCLES = 1,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_preset,
  input  logic              cmd_reverse,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              enable,
  output logic              reverse,
  output logic [0:5]        load,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic armed, hs;
  logic [2:0] preset_q, src;
  logic [STEP_W-1:0] steps_q, scnt;
  logic [3:0] lcnt;
  // armed keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = armed && state == IDLE;
  assign hs = cmd_valid && cmd_ready;
  // the load vector is registered at the accepting edge, so use the incoming preset there
  assign src = hs ? cmd_preset : preset_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hs ? LOAD : IDLE;
      LOAD:    nxt = lcnt == 4'(LOAD_CYCLES - 1) ? SETTLE : LOAD;
      SETTLE:  nxt = steps_q == '0 ? DONE : RUN;
      RUN:     nxt = scnt == STEP_W'(1) ? DONE : RUN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && abort) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      preset_q <= '0;
      steps_q  <= '0;
      scnt     <= '0;
      lcnt     <= '0;
      enable   <= 1'b0;
      reverse  <= 1'b0;
      load     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      if (hs) begin
        preset_q <= cmd_preset;
        steps_q  <= cmd_steps;
        reverse  <= cmd_reverse;
      end
      lcnt   <= (state == LOAD && nxt == LOAD) ? lcnt + 4'd1 : 4'd0;
      scnt   <= state == SETTLE ? steps_q : state == RUN ? scnt - STEP_W'(1) : scnt;
      enable <= nxt == RUN;
      // set and reset of each bit are complementary, so a pair is never both high
      load   <= nxt == LOAD ? {src[0], ~src[0], src[1], ~src[1], src[2], ~src[2]} : 6'b0;
      busy   <= nxt != IDLE;
      done   <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_c1_4_load_sequencer.sv
// tb_c1_4_load_sequencer: randomized bench for two sequencer instances (LOAD_CYCLES 1 and 3).
module tb_c1_4_load_sequencer;
  logic clk = 1'b0;
  logic reset_n, cmd_valid, cmd_reverse, abort;
  logic [2:0] cmd_preset;
  logic [3:0] cmd_steps;
  logic ready_a, enable_a, reverse_a, busy_a, done_a;
  logic ready_b, enable_b, reverse_b, busy_b, done_b;
  logic [0:5] load_a, load_b;
  logic [10:0] obs_a, obs_b;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  c1_4_load_sequencer #(.LOAD_CYCLES(1), .STEP_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_preset(cmd_preset), .cmd_reverse(cmd_reverse), .cmd_steps(cmd_steps),
    .abort(abort), .enable(enable_a), .reverse(reverse_a), .load(load_a),
    .busy(busy_a), .done(done_a));

  c1_4_load_sequencer #(.LOAD_CYCLES(3), .STEP_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_preset(cmd_preset), .cmd_reverse(cmd_reverse), .cmd_steps(cmd_steps),
    .abort(abort), .enable(enable_b), .reverse(reverse_b), .load(load_b),
    .busy(busy_b), .done(done_b));

  assign obs_a = {ready_a, busy_a, done_a, enable_a, reverse_a, load_a};
  assign obs_b = {ready_b, busy_b, done_b, enable_b, reverse_b, load_b};

  // Expected {ready,busy,done,enable,reverse,load[0:5]} in cycle j after an accepting edge.
  // A command spans lc load cycles, one settle, steps enabled cycles and one done cycle;
  // an abort sampled at the end of cycle a makes every later cycle idle; a held
  // command restarts after one idle cycle.
  function automatic logic [10:0] expv(int lc, int steps, int a, bit hold, int j,
                                       logic [2:0] pre, logic rev);
    int total, e, p;
    logic [5:0] pat;
    total = lc + steps + 2;
    e = (a > 0 && a < total) ? a : total;
    p = hold ? ((j - 1) % (total + 1)) + 1 : (j > e ? total + 1 : j);
    pat = {pre[0], ~pre[0], pre[1], ~pre[1], pre[2], ~pre[2]};
    return {p > total, p <= total, p == total, p > lc + 1 && p <= lc + 1 + steps, rev,
            p <= lc ? pat : 6'b0};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(ready_a && ready_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) $display("FAIL wait_idle timeout ready_a=%b ready_b=%b", ready_a, ready_b);
    else passed++;
  endtask

  task automatic run_cmd(input string name, input logic [2:0] pre, input logic rev,
                         input int steps, input int a, input bit hold, input bit ab_hs,
                         input bit noise);
    int ta, tb2, ea, eb, emin, jmax;
    logic [10:0] ex;
    wait_idle();
    ta = 1 + steps + 2;
    tb2 = 3 + steps + 2;
    ea = (a > 0 && a < ta) ? a : ta;
    eb = (a > 0 && a < tb2) ? a : tb2;
    emin = ea < eb ? ea : eb;
    jmax = hold ? 2 * (tb2 + 1) + 1 : tb2 + 2;
    cmd_valid = 1'b1;
    cmd_preset = pre;
    cmd_reverse = rev;
    cmd_steps = steps[3:0];
    abort = ab_hs;
    @(posedge clk);
    for (int j = 1; j <= jmax; j++) begin
      @(negedge clk);
      ex = expv(1, steps, a, hold, j, pre, rev);
      checks++;
      if (obs_a !== ex) $display("FAIL %s lc1 cycle %0d got %b expected %b", name, j, obs_a, ex);
      else passed++;
      ex = expv(3, steps, a, hold, j, pre, rev);
      checks++;
      if (obs_b !== ex) $display("FAIL %s lc3 cycle %0d got %b expected %b", name, j, obs_b, ex);
      else passed++;
      abort = (j == a);
      if (!hold) begin
        // junk commands only while both instances are busy, so they must be ignored
        cmd_valid = noise && j <= emin && ($urandom % 2 == 1);
        cmd_preset = 3'($urandom);
        cmd_reverse = 1'($urandom);
        cmd_steps = 4'($urandom);
      end
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_preset = 3'b111;
    cmd_reverse = 1'b1;
    cmd_steps = 4'd5;
    abort = 1'b0;
    #12;
    checks += 2;
    if (obs_a !== 11'b0) $display("FAIL reset lc1 got %b expected %b", obs_a, 11'b0);
    else passed++;
    if (obs_b !== 11'b0) $display("FAIL reset lc3 got %b expected %b", obs_b, 11'b0);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (obs_a !== 11'b10000000000) $display("FAIL reset_release lc1 got %b expected %b", obs_a, 11'b10000000000);
    else passed++;
    if (obs_b !== 11'b10000000000) $display("FAIL reset_release lc3 got %b expected %b", obs_b, 11'b10000000000);
    else passed++;
  endtask

  task automatic test_basic();
    run_cmd("basic", 3'b101, 1'b0, 3, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_steps();
    run_cmd("zero_steps", 3'b010, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_max_steps();
    run_cmd("max_steps", 3'($urandom), 1'($urandom), 15, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    run_cmd("abort_run", 3'b110, 1'b1, 5, 4, 1'b0, 1'b0, 1'b0);
    run_cmd("after_abort", 3'b011, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    run_cmd("abort_with_accept", 3'b001, 1'b1, 4, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_cmd("random", 3'($urandom), 1'($urandom), int'($urandom % 16),
              ($urandom % 3 == 0) ? int'($urandom_range(1, 20)) : 0,
              1'b0, 1'($urandom), 1'b1);
  endtask

  task automatic test_back_to_back();
    run_cmd("back_to_back", 3'b100, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_load();
    logic [2:0] pre;
    logic [5:0] pat;
    wait_idle();
    pre = 3'($urandom);
    pat = {pre[0], ~pre[0], pre[1], ~pre[1], pre[2], ~pre[2]};
    cmd_valid = 1'b1;
    cmd_preset = pre;
    cmd_reverse = 1'b1;
    cmd_steps = 4'd6;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    checks += 2;
    if (load_a !== pat) $display("FAIL load_before_reset lc1 got %b expected %b", load_a, pat);
    else passed++;
    if (load_b !== pat) $display("FAIL load_before_reset lc3 got %b expected %b", load_b, pat);
    else passed++;
    reset_n = 1'b0;
    #1;
    checks += 2;
    if (obs_a !== 11'b0) $display("FAIL async_reset lc1 got %b expected %b", obs_a, 11'b0);
    else passed++;
    if (obs_b !== 11'b0) $display("FAIL async_reset lc3 got %b expected %b", obs_b, 11'b0);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (obs_a !== 11'b10000000000) $display("FAIL reset_recover lc1 got %b expected %b", obs_a, 11'b10000000000);
    else passed++;
    if (obs_b !== 11'b10000000000) $display("FAIL reset_recover lc3 got %b expected %b", obs_b, 11'b10000000000);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_max_steps();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_in_load();
    test_basic();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/c1_4_load_sequencer.md
Name: c1_4_load_sequencer

Overview:
- Control stage directly upstream of the 3-loadable-bit T-flip-flop up/down counter (outputs Q[1:4], Q[4] tied 0).
- Accepts a command {preset, direction, step count} over a valid/ready handshake.
- Drives the counter's async set/reset load vector to force the preset, then asserts enable for exactly the requested number of clock steps in the requested direction.
- Reports completion with a done pulse.

Parameters:
LOAD_CYCLES, 1, number of clock cycles the load vector is held asserted (legal 1..15)
STEP_W, 4, width of the step-count field

Ports:
clk  input  1  rising-edge clock, shared with the counter
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_preset  input  3  value forced into counter; bit i maps to Q[i+1]
cmd_reverse  input  1  direction for the run phase, passed to the counter's reverse input
cmd_steps  input  STEP_W  number of enabled clock cycles in the run phase (0 allowed)
abort  input  1  synchronous cancel of the current command
enable  output  1  counter enable
reverse  output  1  counter direction
load  output  6  indexed [0:5]; load[2i] = async set of Q[i+1], load[2i+1] = async reset of Q[i+1], active-high
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, reset_n.
- While reset_n is low, all outputs are 0:
  - enable=0, reverse=0, load=6'b000000, busy=0, done=0, cmd_ready=0.
  - State is IDLE; step counter and latched fields are cleared.
- After reset release, cmd_ready=1 from the first clock edge onward.
- All outputs except cmd_ready are registered. cmd_ready is decoded from state: 1 only in IDLE.
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - A handshake is cmd_valid&cmd_ready sampled at a rising edge.
  - On a handshake, latch preset, reverse and steps, and go to LOAD.
  - The reverse output takes the latched value at the same edge.
- LOAD:
  - Lasts exactly LOAD_CYCLES cycles; a cycle counter is cleared on entry.
  - load[2i] = preset[i] and load[2i+1] = ~preset[i], for i=0..2.
  - enable=0.
  - Invariant: a set/reset pair is never both 1.
- SETTLE: one cycle; load=0, enable=0. Guarantees the async set/reset is released before the first enabled edge.
- RUN:
  - enable=1; the step counter decrements every cycle.
  - Exits to DONE after exactly steps cycles with enable high.
  - If steps==0, SETTLE goes straight to DONE and enable never rises.
- DONE:
  - done=1 for exactly one cycle; enable=0, load=0.
  - Next state is IDLE; cmd_ready rises the cycle after done.
- reverse changes only on a command acceptance. It stays stable through LOAD, SETTLE, RUN and DONE, and holds its value in IDLE.
- Latency, for a handshake at edge k:
  - load is visible cycles k+1 .. k+LOAD_CYCLES.
  - SETTLE occupies cycle k+LOAD_CYCLES+1.
  - enable is high cycles k+LOAD_CYCLES+2 .. k+LOAD_CYCLES+1+steps.
  - done is high the following cycle.
- abort:
  - Sampled in any non-IDLE state; the next state is IDLE.
  - load=0 and enable=0 from the next edge; no done pulse.
  - abort in IDLE is ignored.
  - abort and cmd_valid high together in IDLE: the command is accepted (abort ignored).
- cmd_valid while busy: no handshake (cmd_ready=0). The command must be held by the producer and is not latched.
- Asserting reset_n low mid-operation clears load and enable asynchronously, with no glitch to 1.
- Step counter is STEP_W bits and never wraps: a value of 2^STEP_W-1 gives that many enabled cycles.

Test Plan:
- Reset then idle: reset_n low with cmd_valid=1 -> all outputs 0; after release cmd_ready=1, busy=0, load=000000.
- Basic command, LOAD_CYCLES=1: preset=3'b101, reverse=0, steps=3 -> one cycle load=100110, one SETTLE cycle, enable high exactly 3 cycles, done pulse. Counter Q[1:3] advances from preset 101 by 3 up-count steps.
- Zero steps: preset=3'b010, reverse=1, steps=0 -> load=011001 for one cycle, SETTLE, enable never 1, done one cycle after SETTLE, reverse=1 throughout.
- Long load with max steps: LOAD_CYCLES=3, steps=15 -> load held 3 cycles, enable high 15 consecutive cycles, busy high for 3+1+15+1=20 cycles.
- Abort mid-run: abort=1 on the 2nd RUN cycle of a steps=5 command -> enable=0 next cycle, no done pulse, cmd_ready=1 the cycle after; a new command is then accepted normally.
- Back-to-back and busy: cmd_valid held high across two commands -> second accepted only in the cycle after done; a cmd_valid pulse during RUN is ignored. Async reset asserted during LOAD -> load drops to 000000 immediately.
